cpu_control_unit: RTL and testbench

//  Top of the 16-bit single-cycle processor: PC, instruction ROM, decoder, 8x16 register file,
//  ALU and data RAM in one block. Executes one instruction per clock. Only clk/reset are external.

---
 rtl/cpu_control_unit.sv | 163 ++++++++++++++++
 tb/tb_cpu_control_unit.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/cpu_control_unit.sv
// 16-bit single-cycle processor: PC, instruction ROM, decoder, 8x16 register
// file, ALU and data RAM. One instruction retires on every rising clock edge.

// Eight 16-bit registers with x0 hardwired to zero; two async read ports.
module RegFile (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  rs1Addr,
  input  logic [2:0]  rs2Addr,
  output logic [15:0] rs1Data,
  output logic [15:0] rs2Data,
  input  logic        writeEnable,
  input  logic [2:0]  rdAddr,
  input  logic [15:0] rdData
);

  logic [15:0] reg_file [0:7];

  assign rs1Data = (rs1Addr == 3'd0) ? 16'h0000 : reg_file[rs1Addr];
  assign rs2Data = (rs2Addr == 3'd0) ? 16'h0000 : reg_file[rs2Addr];

  // Clear every register on reset; writes aimed at x0 are dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++) reg_file[i] <= 16'h0000;
    end else if (writeEnable && (rdAddr != 3'd0)) begin
      reg_file[rdAddr] <= rdData;
    end
  end

endmodule

module cpu_control_unit #(
  parameter int IMEM_DEPTH = 256,
  parameter int DMEM_DEPTH = 256
) (
  input  logic clk,
  input  logic reset
);

  // ROM contents are loaded from outside and survive reset.
  logic [15:0] instruction_rom [0:IMEM_DEPTH-1] = '{default: 16'h0000};
  logic [15:0] dataRam [0:DMEM_DEPTH-1];

  logic [15:0] pc;
  logic [15:0] pc_d;
  logic [15:0] instruction;

  logic [2:0]  opcode;
  logic [2:0]  alu_op;
  logic [15:0] alu_result;
  logic        reg_write;
  logic        mem_read;
  logic        mem_write;
  logic        branch;
  logic        jump;

  logic [2:0]  rs1Addr;
  logic [2:0]  rs2Addr;
  logic [2:0]  rdAddr;
  logic [15:0] immExt;
  logic [15:0] luiImm;
  logic        useImm;
  logic [15:0] rs1Data;
  logic [15:0] rs2Data;
  logic [15:0] aluB;
  logic [15:0] memReadData;
  logic [15:0] rdData;
  logic        branchTaken;

  assign instruction = instruction_rom[pc[7:0]];
  assign opcode      = instruction[15:13];
  assign immExt      = {{9{instruction[6]}}, instruction[6:0]};
  assign luiImm      = {instruction[9:0], 6'b000000};
  assign jump        = 1'b0;

  // Decode register fields and control lines from the opcode.
  always_comb begin
    rdAddr    = instruction[12:10];
    rs1Addr   = instruction[9:7];
    rs2Addr   = 3'd0;
    alu_op    = 3'b000;
    reg_write = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    branch    = 1'b0;
    useImm    = 1'b1;
    case (opcode)
      3'b000, 3'b010: begin
        rdAddr    = instruction[11:9];
        rs1Addr   = instruction[8:6];
        rs2Addr   = instruction[5:3];
        useImm    = 1'b0;
        reg_write = 1'b1;
        alu_op    = (opcode == 3'b010) ? 3'b001 : 3'b000;
      end
      3'b001: reg_write = 1'b1;
      3'b011: begin
        reg_write = 1'b1;
        alu_op    = 3'b001;
      end
      3'b100: begin
        reg_write = 1'b1;
        alu_op    = 3'b010;
      end
      3'b101: begin
        rs1Addr = instruction[12:10];
        rs2Addr = instruction[9:7];
        useImm  = 1'b0;
        branch  = 1'b1;
        alu_op  = 3'b001;
      end
      3'b110: begin
        rs2Addr   = instruction[12:10];
        mem_write = 1'b1;
      end
      default: begin
        reg_write = 1'b1;
        mem_read  = 1'b1;
      end
    endcase
  end

  RegFile rf (
    .clk        (clk),
    .reset      (reset),
    .rs1Addr    (rs1Addr),
    .rs2Addr    (rs2Addr),
    .rs1Data    (rs1Data),
    .rs2Data    (rs2Data),
    .writeEnable(reg_write),
    .rdAddr     (rdAddr),
    .rdData     (rdData)
  );

  // ALU: add, subtract (also the BEQ compare) or pass the LUI immediate.
  always_comb begin
    aluB = useImm ? immExt : rs2Data;
    case (alu_op)
      3'b000:  alu_result = rs1Data + aluB;
      3'b001:  alu_result = rs1Data - aluB;
      3'b010:  alu_result = luiImm;
      default: alu_result = 16'h0000;
    endcase
  end

  assign memReadData = dataRam[alu_result[7:0]];
  assign rdData      = mem_read ? memReadData : alu_result;
  assign branchTaken = (branch && (alu_result == 16'h0000)) || jump;
  assign pc_d        = branchTaken ? (pc + 16'd1 + immExt) : (pc + 16'd1);

  // Data RAM has no reset and ignores stores while reset is held.
  always_ff @(posedge clk) begin
    if (reset && mem_write) dataRam[alu_result[7:0]] <= rs2Data;
  end

  // Program counter: cleared asynchronously, otherwise advances every cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pc <= 16'h0000;
    else        pc <= pc_d;
  end

endmodule

// File: tb/tb_cpu_control_unit.sv
// Directed bench for cpu_control_unit: decode table plus program sequences.
module tb_cpu_control_unit;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int testCount = 0;
  int failCount = 0;

  cpu_control_unit dut (
    .clk  (clk),
    .reset(reset)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] instr;
    logic [2:0]  aluOp;
    logic        regWrite;
    logic        memRead;
    logic        memWrite;
    logic        branch;
    logic [15:0] aluResult;
  } DecodeVec;

  function automatic logic [15:0] encR(input logic [2:0] op, input int rd, input int rs1, input int rs2);
    encR = {op, 1'b0, rd[2:0], rs1[2:0], rs2[2:0], 3'b000};
  endfunction

  function automatic logic [15:0] encI(input logic [2:0] op, input int rd, input int rs1, input logic [6:0] imm);
    encI = {op, rd[2:0], rs1[2:0], imm};
  endfunction

  function automatic logic [15:0] encLui(input int rd, input logic [9:0] imm);
    encLui = {3'b100, rd[2:0], imm};
  endfunction

  function automatic logic [15:0] encBeq(input int rs1, input int rs2, input logic [6:0] off);
    encBeq = {3'b101, rs1[2:0], rs2[2:0], off};
  endfunction

  function automatic logic [15:0] encSw(input int rs2, input int rs1, input logic [6:0] imm);
    encSw = {3'b110, rs2[2:0], rs1[2:0], imm};
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic runCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Hold reset, reload the ROM with a program (rest NOPs), release on a falling edge.
  task automatic applyStimulus(input logic [15:0] words [$]);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 256; i++) dut.instruction_rom[i] = 16'h0000;
    for (int i = 0; i < words.size(); i++) dut.instruction_rom[i] = words[i];
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic checkRegs(input string tag, input logic [15:0] exp [8]);
    for (int i = 0; i < 8; i++)
      checkOutput($sformatf("%s x%0d", tag, i), dut.rf.reg_file[i], exp[i]);
  endtask

  DecodeVec vecs [8];
  logic [15:0] prog [$];
  logic [15:0] fibProg [$];
  logic [15:0] expFib [8];
  logic [15:0] expZero [8];

  initial begin
    vecs[0] = '{"ADD",  encR(3'b000, 3, 1, 2),     3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000};
    vecs[1] = '{"SUB",  encR(3'b010, 3, 1, 2),     3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000};
    vecs[2] = '{"ADDI", encI(3'b001, 1, 0, 7'd5),  3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0005};
    vecs[3] = '{"SUBI", encI(3'b011, 2, 1, 7'd7),  3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 16'hFFF9};
    vecs[4] = '{"LUI",  encLui(4, 10'h3FF),        3'b010, 1'b1, 1'b0, 1'b0, 1'b0, 16'hFFC0};
    vecs[5] = '{"BEQ",  encBeq(0, 0, 7'd2),        3'b001, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000};
    vecs[6] = '{"SW",   encSw(1, 0, 7'd3),         3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0003};
    vecs[7] = '{"LW",   encI(3'b111, 5, 0, 7'd3),  3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0003};

    expZero = '{default: 16'h0000};
    expFib  = '{16'd0, 16'd1, 16'd1, 16'd2, 16'd3, 16'd5, 16'd8, 16'd13};
    fibProg = '{encI(3'b001, 1, 0, 7'd1), encI(3'b001, 2, 0, 7'd1),
                encR(3'b000, 3, 1, 2), encR(3'b000, 4, 2, 3), encR(3'b000, 5, 3, 4),
                encR(3'b000, 6, 4, 5), encR(3'b000, 7, 5, 6), encR(3'b000, 0, 6, 7)};

    // Decode table: held in reset so pc=0 and all registers read zero.
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      dut.instruction_rom[0] = vecs[i].instr;
      #1;
      checkOutput({vecs[i].name, " ctrl"},
                  {8'h00, vecs[i].aluOp, vecs[i].regWrite, vecs[i].memRead, vecs[i].memWrite, vecs[i].branch, 1'b0},
                  {8'h00, dut.alu_op, dut.reg_write, dut.mem_read, dut.mem_write, dut.branch, dut.jump});
      checkOutput({vecs[i].name, " alu"}, dut.alu_result, vecs[i].aluResult);
    end

    // NOP stream from an all-zero ROM.
    prog = {};
    applyStimulus(prog);
    checkOutput("nop pc0", dut.pc, 16'd0);
    runCycles(1);
    checkOutput("nop pc1", dut.pc, 16'd1);
    runCycles(2);
    checkOutput("nop pc3", dut.pc, 16'd3);
    checkRegs("nop", expZero);

    // ROM wraps at 256 while pc keeps counting.
    prog = '{encI(3'b001, 1, 1, 7'd1)};
    applyStimulus(prog);
    runCycles(256);
    checkOutput("wrap pc", dut.pc, 16'h0100);
    checkOutput("wrap x1a", dut.rf.reg_file[1], 16'd1);
    runCycles(1);
    checkOutput("wrap pc+1", dut.pc, 16'h0101);
    checkOutput("wrap x1b", dut.rf.reg_file[1], 16'd2);

    // Fibonacci.
    applyStimulus(fibProg);
    runCycles(8);
    checkRegs("fib", expFib);
    checkOutput("fib pc", dut.pc, 16'd8);

    // Arithmetic, LUI, then store/load round trip.
    prog = '{encI(3'b001, 1, 0, 7'd5), encI(3'b011, 2, 1, 7'd7), encR(3'b010, 3, 0, 2),
             encLui(4, 10'h3FF), encSw(1, 0, 7'd3), encI(3'b111, 5, 0, 7'd3)};
    applyStimulus(prog);
    runCycles(4);
    checkOutput("arith x1", dut.rf.reg_file[1], 16'h0005);
    checkOutput("arith x2", dut.rf.reg_file[2], 16'hFFFE);
    checkOutput("arith x3", dut.rf.reg_file[3], 16'h0002);
    checkOutput("arith x4", dut.rf.reg_file[4], 16'hFFC0);
    checkOutput("sw memwrite", {15'd0, dut.mem_write}, 16'd1);
    checkOutput("sw regwrite", {15'd0, dut.reg_write}, 16'd0);
    runCycles(1);
    checkOutput("lw memread", {15'd0, dut.mem_read}, 16'd1);
    checkOutput("lw regwrite", {15'd0, dut.reg_write}, 16'd1);
    runCycles(1);
    checkOutput("lw x5", dut.rf.reg_file[5], 16'h0005);

    // BEQ taken forward.
    prog = '{16'h0, 16'h0, 16'h0, 16'h0, encBeq(0, 0, 7'd2)};
    applyStimulus(prog);
    runCycles(4);
    checkOutput("beq branch", {15'd0, dut.branch}, 16'd1);
    runCycles(1);
    checkOutput("beq taken pc", dut.pc, 16'd7);

    // BEQ not taken.
    prog = '{encI(3'b001, 1, 0, 7'd1), 16'h0, 16'h0, 16'h0, encBeq(1, 0, 7'd2)};
    applyStimulus(prog);
    runCycles(5);
    checkOutput("beq untaken pc", dut.pc, 16'd5);

    // BEQ with offset -1 loops on itself.
    prog = '{16'h0, 16'h0, 16'h0, 16'h0, encBeq(0, 0, 7'h7F)};
    applyStimulus(prog);
    runCycles(5);
    checkOutput("beq self pc", dut.pc, 16'd4);
    runCycles(3);
    checkOutput("beq self pc2", dut.pc, 16'd4);

    // Asynchronous reset mid-program, then re-run.
    applyStimulus(fibProg);
    runCycles(4);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async pc", dut.pc, 16'd0);
    checkRegs("async", expZero);
    @(negedge clk);
    reset = 1'b1;
    runCycles(8);
    checkRegs("rerun", expFib);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
